// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller with frame-aligned digit updates,
// "Erro" message sequencing, leading-zero blanking and per-slot guard time.
module display_scan_controller #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic        error,
  input  logic        blank_lz,
  output logic [3:0]  code,
  output logic [3:0]  digit_n,
  output logic        frame_done
);

  localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DRIVE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic          pend_q, pend_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          err_q, err_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    dn_q, dn_d;
  logic          fd_q, fd_d;

  logic          boundary;
  logic          fault;
  logic          blank;
  logic [3:0]    nib;
  logic [3:0]    err_code;

  // State, counters, buffers and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      slot_q   <= 2'd0;
      cnt_q    <= '0;
      hold_q   <= 16'h0000;
      pend_q   <= 1'b0;
      shadow_q <= 16'h0000;
      err_q    <= 1'b0;
      code_q   <= 4'h0;
      dn_q     <= 4'hF;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      code_q   <= code_d;
      dn_q     <= dn_d;
      fd_q     <= fd_d;
    end
  end

  // Next state; outputs are derived from the next-state values so that each
  // slot's code/select are already valid on the slot's first cycle.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    fault    = 1'b0;
    blank    = 1'b0;
    nib      = 4'h0;
    err_code = 4'h0;
    code_d   = 4'h0;
    dn_d     = 4'hF;
    fd_d     = 1'b0;

    // Frame boundary: leaving IDLE, or the last cycle of slot 3
    boundary = enable && ((state_q == S_IDLE) || ((slot_q == 2'd3) && (cnt_q == LAST)));

    // Slot/cycle sequencing; counters sit at zero while disabled
    if (!enable) begin
      state_d = S_IDLE;
      slot_d  = 2'd0;
      cnt_d   = '0;
    end else begin
      if (state_q == S_IDLE) begin
        slot_d = 2'd0;
        cnt_d  = '0;
      end else if (cnt_q == LAST) begin
        slot_d = slot_q + 2'd1;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
      state_d = (int'(cnt_d) < GUARD) ? S_GUARD : S_DRIVE;
    end

    // Double buffering: a load on the boundary cycle bypasses the holding register
    if (boundary) begin
      if (load) begin
        shadow_d = digits;
        hold_d   = digits;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = hold_q;
        pend_d   = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (shadow_d[4*i +: 4] > 4'd9) fault = 1'b1;
      end
      err_d = error | fault;
    end else if (load) begin
      hold_d = digits;
      pend_d = 1'b1;
    end

    nib = shadow_d[{slot_d, 2'b00} +: 4];

    case (slot_d)
      2'd0:    err_code = 4'b1111;  // 'o'
      2'd1:    err_code = 4'b1110;  // 'r'
      2'd2:    err_code = 4'b1110;  // 'r'
      default: err_code = 4'b1100;  // 'E'
    endcase

    // Leading-zero suppression follows blank_lz live, never in error mode
    if (blank_lz && !err_d) begin
      case (slot_d)
        2'd3:    blank = (shadow_d[15:12] == 4'h0);
        2'd2:    blank = (shadow_d[15:8]  == 8'h00);
        2'd1:    blank = (shadow_d[15:4]  == 12'h000);
        default: blank = 1'b0;
      endcase
    end

    if (state_d != S_IDLE) begin
      code_d = err_d ? err_code : nib;
      if ((state_d == S_DRIVE) && !blank) dn_d = ~(4'b0001 << slot_d);
      fd_d   = (slot_d == 2'd3) && (cnt_d == LAST);
    end
  end

  assign code       = code_q;
  assign digit_n    = dn_q;
  assign frame_done = fd_q;

endmodule
